// File: rtl/mips_defines.sv
// mips_defines: shared LSU size encodings, FSM states and data width
package mips_defines;
    localparam int MIPS_DATA_WIDTH = 32;
    localparam logic [1:0] MIPS_LSU_SIZE_B = 2'b00;
    localparam logic [1:0] MIPS_LSU_SIZE_H = 2'b01;
    localparam logic [1:0] MIPS_LSU_SIZE_W = 2'b10;
    typedef enum logic [1:0] {LSU_IDLE, LSU_REQ, LSU_WAIT, LSU_DONE} lsu_state_t;
endpackage

// File: rtl/mips_mem_lsu_align.sv
// mips_mem_lsu_align: store lane replication/strobes and load extract/extend (size 11 acts as word)
module mips_mem_lsu_align
    import mips_defines::*;
(
    input  logic [1:0]                 addr_lo,
    input  logic [1:0]                 size,
    input  logic                       usign,
    input  logic                       write,
    input  logic [MIPS_DATA_WIDTH-1:0] wdat,
    input  logic [MIPS_DATA_WIDTH-1:0] rdat,
    output logic [MIPS_DATA_WIDTH-1:0] st_data,
    output logic [MIPS_DATA_WIDTH-1:0] ld_data,
    output logic [3:0]                 st_strb
);
    logic        is_b;
    logic        is_h;
    logic [7:0]  b;
    logic [15:0] h;
    assign is_b = size == MIPS_LSU_SIZE_B;
    assign is_h = size == MIPS_LSU_SIZE_H;
    // pick the addressed byte/half of the read word; half lane uses addr[1] only
    always_comb begin
        b = rdat[{addr_lo, 3'b000} +: 8];
        h = addr_lo[1] ? rdat[31:16] : rdat[15:0];
    end
    assign ld_data = is_b ? {{24{~usign & b[7]}}, b} :
                     is_h ? {{16{~usign & h[15]}}, h} : rdat;
    assign st_data = is_b ? {4{wdat[7:0]}} : is_h ? {2{wdat[15:0]}} : wdat;
    assign st_strb = ~write ? 4'b0000 :
                     is_b ? 4'b0001 << addr_lo :
                     is_h ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
endmodule

// File: rtl/mips_mem_lsu.sv
// mips_mem_lsu: MEM-stage load/store unit; MIPS_LSU_MISALIGN_EXCP_EN turns misaligned accesses into bus-less flagged completions
module mips_mem_lsu
    import mips_defines::*;
#(
    parameter int DATA_WIDTH = MIPS_DATA_WIDTH,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lsu_req_valid,
    input  logic                  lsu_req_read,
    input  logic                  lsu_req_write,
    input  logic [ADDR_WIDTH-1:0] lsu_req_addr,
    input  logic [DATA_WIDTH-1:0] lsu_req_wdat,
    input  logic [1:0]            lsu_req_size,
    input  logic                  lsu_req_usign,
    output logic                  lsu_stall,
    output logic                  dmem_req_valid,
    input  logic                  dmem_req_ready,
    output logic                  dmem_req_write,
    output logic [ADDR_WIDTH-1:0] dmem_req_addr,
    output logic [DATA_WIDTH-1:0] dmem_req_wdat,
    output logic [3:0]            dmem_req_wstrb,
    input  logic                  dmem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] dmem_rsp_rdat,
    output logic                  lsu_wb_valid,
    output logic [DATA_WIDTH-1:0] lsu_wb_data,
    output logic                  lsu_misalign
);
    lsu_state_t            state;
    lsu_state_t            next;
    logic                  go;
    logic                  write_q;
    logic                  usign_q;
    logic [1:0]            size_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdat_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] ld_data;
    assign go = lsu_req_valid & (lsu_req_read | lsu_req_write);
`ifdef MIPS_LSU_MISALIGN_EXCP_EN
    logic mis_in;
    logic mis_q;
    assign mis_in = lsu_req_size[1] ? |lsu_req_addr[1:0] : lsu_req_size[0] & lsu_req_addr[0];
    assign lsu_misalign = (state == LSU_DONE) & mis_q;
`else
    assign lsu_misalign = 1'b0;
`endif
    // next-state logic and pipeline stall
    always_comb begin
        next = state;
        lsu_stall = (state == LSU_IDLE & go) | state == LSU_REQ | state == LSU_WAIT;
        case (state)
`ifdef MIPS_LSU_MISALIGN_EXCP_EN
            LSU_IDLE: if (go) next = mis_in ? LSU_DONE : LSU_REQ;
`else
            LSU_IDLE: if (go) next = LSU_REQ;
`endif
            LSU_REQ:  if (dmem_req_ready) next = LSU_WAIT;
            LSU_WAIT: if (dmem_rsp_valid) next = LSU_DONE;
            default:  next = LSU_IDLE;
        endcase
    end
    // state register, request capture and formatted response capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= LSU_IDLE;
            write_q <= 1'b0;
            usign_q <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdat_q  <= '0;
            data_q  <= '0;
`ifdef MIPS_LSU_MISALIGN_EXCP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state <= next;
            if (state == LSU_IDLE && go) begin
                write_q <= lsu_req_write;
                usign_q <= lsu_req_usign;
                size_q  <= lsu_req_size;
                addr_q  <= lsu_req_addr;
                wdat_q  <= lsu_req_wdat;
                data_q  <= '0;
`ifdef MIPS_LSU_MISALIGN_EXCP_EN
                mis_q   <= mis_in;
`endif
            end
            if (state == LSU_WAIT && dmem_rsp_valid) data_q <= write_q ? '0 : ld_data;
        end
    end
    assign dmem_req_valid = state == LSU_REQ;
    assign dmem_req_write = write_q;
    assign dmem_req_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign lsu_wb_valid   = state == LSU_DONE;
    assign lsu_wb_data    = state == LSU_DONE ? data_q : '0;
    mips_mem_lsu_align u_align (
        .addr_lo (addr_q[1:0]),
        .size    (size_q),
        .usign   (usign_q),
        .write   (write_q),
        .wdat    (wdat_q),
        .rdat    (dmem_rsp_rdat),
        .st_data (dmem_req_wdat),
        .ld_data (ld_data),
        .st_strb (dmem_req_wstrb)
    );
endmodule

// File: tb/tb_mips_mem_lsu.sv
// tb_mips_mem_lsu: directed self-checking bench for the MEM-stage load/store unit
module tb_mips_mem_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_req_valid, lsu_req_read, lsu_req_write, lsu_req_usign;
    logic [31:0] lsu_req_addr, lsu_req_wdat;
    logic [1:0]  lsu_req_size;
    logic        lsu_stall, dmem_req_valid, dmem_req_ready, dmem_req_write;
    logic [31:0] dmem_req_addr, dmem_req_wdat, dmem_rsp_rdat, lsu_wb_data;
    logic [3:0]  dmem_req_wstrb;
    logic        dmem_rsp_valid, lsu_wb_valid, lsu_misalign;
    int checks = 0;
    int errors = 0;
    logic [31:0] r_wb, r_addr, r_wdat;
    logic [3:0]  r_strb;
    logic        r_write, r_mis;
    int          r_lat, r_pulses, r_stall, r_reqs;
    bit          r_stable;

    mips_mem_lsu dut (
        .clk(clk), .rst(rst),
        .lsu_req_valid(lsu_req_valid), .lsu_req_read(lsu_req_read), .lsu_req_write(lsu_req_write),
        .lsu_req_addr(lsu_req_addr), .lsu_req_wdat(lsu_req_wdat), .lsu_req_size(lsu_req_size),
        .lsu_req_usign(lsu_req_usign), .lsu_stall(lsu_stall),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_req_write(dmem_req_write),
        .dmem_req_addr(dmem_req_addr), .dmem_req_wdat(dmem_req_wdat), .dmem_req_wstrb(dmem_req_wstrb),
        .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdat(dmem_rsp_rdat),
        .lsu_wb_valid(lsu_wb_valid), .lsu_wb_data(lsu_wb_data), .lsu_misalign(lsu_misalign)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // one request from IDLE; ready after rdy_dly REQ cycles, response after rsp_dly WAIT cycles
    task automatic xact(input logic rdf, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] sz, input logic us, input logic [31:0] rd,
                        input int rdy_dly, input int rsp_dly);
        bit hs = 0;
        bit given = 0;
        int wait_cnt = 0;
        r_wb = 0; r_addr = 0; r_wdat = 0; r_strb = 0; r_write = 0; r_mis = 0;
        r_lat = -1; r_pulses = 0; r_stall = 0; r_reqs = 0; r_stable = 1;
        lsu_req_read = rdf; lsu_req_write = wr; lsu_req_addr = addr; lsu_req_wdat = wd;
        lsu_req_size = sz; lsu_req_usign = us; dmem_rsp_rdat = rd;
        for (int c = 0; c < 60; c++) begin
            lsu_req_valid = (c == 0);
            dmem_rsp_valid = hs && !given && wait_cnt >= rsp_dly;
            if (dmem_rsp_valid) given = 1;
            if (hs) wait_cnt++;
            #1;
            if (lsu_stall) r_stall++;
            if (dmem_req_valid) begin
                r_reqs++;
                if (r_reqs == 1) begin
                    r_addr = dmem_req_addr; r_wdat = dmem_req_wdat; r_strb = dmem_req_wstrb; r_write = dmem_req_write;
                end else if ({r_addr, r_wdat, r_strb, r_write} !== {dmem_req_addr, dmem_req_wdat, dmem_req_wstrb, dmem_req_write}) begin
                    r_stable = 0;
                end
            end
            if (lsu_wb_valid) begin
                r_pulses++;
                if (r_pulses == 1) begin
                    r_wb = lsu_wb_data; r_lat = c; r_mis = lsu_misalign;
                end
            end
            dmem_req_ready = dmem_req_valid && r_reqs > rdy_dly;
            if (dmem_req_ready) hs = 1;
            if (r_lat >= 0 && c >= r_lat + 2) break;
            step();
        end
        lsu_req_valid = 0; dmem_req_ready = 0; dmem_rsp_valid = 0;
    endtask

    task automatic test_reset;
        rst = 1; lsu_req_valid = 0; lsu_req_read = 0; lsu_req_write = 0; lsu_req_addr = 32'h1234_5677;
        lsu_req_wdat = 32'hFFFF_FFFF; lsu_req_size = 2'b10; lsu_req_usign = 0;
        dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rsp_rdat = 32'hFFFF_FFFF;
        step(); step();
        checks++; if ({lsu_stall, dmem_req_valid, dmem_req_write, lsu_wb_valid, lsu_misalign} !== 5'b0) begin errors++; $display("FAIL reset_ctrl got %b want 00000", {lsu_stall, dmem_req_valid, dmem_req_write, lsu_wb_valid, lsu_misalign}); end
        checks++; if ({dmem_req_addr, dmem_req_wdat, dmem_req_wstrb} !== 68'h0) begin errors++; $display("FAIL reset_req got %h %h %b want 0", dmem_req_addr, dmem_req_wdat, dmem_req_wstrb); end
        checks++; if (lsu_wb_data !== 32'h0) begin errors++; $display("FAIL reset_wb_data got %h want 0", lsu_wb_data); end
        rst = 0;
        step();
    endtask

    task automatic test_ignore;
        lsu_req_valid = 1; lsu_req_read = 0; lsu_req_write = 0;
        #1;
        checks++; if (lsu_stall !== 1'b0) begin errors++; $display("FAIL ignore_stall got %b want 0", lsu_stall); end
        step();
        lsu_req_valid = 0;
        #1;
        checks++; if (dmem_req_valid !== 1'b0) begin errors++; $display("FAIL ignore_req got %b want 0", dmem_req_valid); end
        step();
    endtask

    task automatic test_store;
        xact(0, 1, 32'h0000_1003, 32'hAABB_CCDD, 2'b00, 0, 32'h0, 0, 0);
        checks++; if (r_addr !== 32'h0000_1000) begin errors++; $display("FAIL sb_addr got %h want 00001000", r_addr); end
        checks++; if (r_wdat !== 32'hDDDD_DDDD) begin errors++; $display("FAIL sb_wdat got %h want dddddddd", r_wdat); end
        checks++; if ({r_strb, r_write} !== 5'b1000_1) begin errors++; $display("FAIL sb_strb_write got %b want 10001", {r_strb, r_write}); end
        checks++; if (r_lat !== 3) begin errors++; $display("FAIL sb_latency got %0d want 3", r_lat); end
        checks++; if (r_stall !== 3) begin errors++; $display("FAIL sb_stall_cycles got %0d want 3", r_stall); end
        checks++; if ({r_pulses, r_wb} !== {32'd1, 32'h0}) begin errors++; $display("FAIL sb_wb got pulses %0d data %h want 1 0", r_pulses, r_wb); end
        xact(0, 1, 32'h0000_1002, 32'h1122_3344, 2'b01, 0, 32'h0, 0, 0);
        checks++; if ({r_wdat, r_strb} !== {32'h3344_3344, 4'b1100}) begin errors++; $display("FAIL sh got %h %b want 33443344 1100", r_wdat, r_strb); end
        xact(0, 1, 32'h0000_1004, 32'hCAFE_BABE, 2'b10, 0, 32'h0, 0, 0);
        checks++; if ({r_addr, r_wdat, r_strb} !== {32'h0000_1004, 32'hCAFE_BABE, 4'b1111}) begin errors++; $display("FAIL sw got %h %h %b want 00001004 cafebabe 1111", r_addr, r_wdat, r_strb); end
        xact(1, 1, 32'h0000_1001, 32'h0000_00A5, 2'b00, 0, 32'h0, 0, 0);
        checks++; if ({r_write, r_wdat, r_strb} !== {1'b1, 32'hA5A5_A5A5, 4'b0010}) begin errors++; $display("FAIL rw_as_store got %b %h %b want 1 a5a5a5a5 0010", r_write, r_wdat, r_strb); end
    endtask

    task automatic test_load;
        xact(1, 0, 32'h0000_2002, 32'h0, 2'b00, 0, 32'h12F4_5678, 0, 0);
        checks++; if (r_wb !== 32'hFFFF_FFF4) begin errors++; $display("FAIL lb got %h want fffffff4", r_wb); end
        checks++; if ({r_addr, r_strb, r_write} !== {32'h0000_2000, 4'b0000, 1'b0}) begin errors++; $display("FAIL lb_req got %h %b %b want 00002000 0000 0", r_addr, r_strb, r_write); end
        xact(1, 0, 32'h0000_2002, 32'h0, 2'b00, 1, 32'h12F4_5678, 0, 0);
        checks++; if (r_wb !== 32'h0000_00F4) begin errors++; $display("FAIL lbu got %h want 000000f4", r_wb); end
        xact(1, 0, 32'h0000_2001, 32'h0, 2'b00, 0, 32'h12F4_5678, 0, 0);
        checks++; if (r_wb !== 32'h0000_0056) begin errors++; $display("FAIL lb_lane1 got %h want 00000056", r_wb); end
        xact(1, 0, 32'h0000_2002, 32'h0, 2'b01, 0, 32'h8001_7FFF, 0, 0);
        checks++; if (r_wb !== 32'hFFFF_8001) begin errors++; $display("FAIL lh got %h want ffff8001", r_wb); end
        xact(1, 0, 32'h0000_2000, 32'h0, 2'b01, 1, 32'h8001_7FFF, 0, 0);
        checks++; if (r_wb !== 32'h0000_7FFF) begin errors++; $display("FAIL lhu got %h want 00007fff", r_wb); end
        xact(1, 0, 32'h0000_2000, 32'h0, 2'b10, 0, 32'h8001_7FFF, 0, 0);
        checks++; if ({r_wb, r_lat} !== {32'h8001_7FFF, 32'd3}) begin errors++; $display("FAIL lw got %h lat %0d want 80017fff 3", r_wb, r_lat); end
        xact(1, 0, 32'h0000_2000, 32'h0, 2'b11, 0, 32'h8001_7FFF, 0, 0);
        checks++; if (r_wb !== 32'h8001_7FFF) begin errors++; $display("FAIL size11 got %h want 80017fff", r_wb); end
    endtask

    task automatic test_backpressure;
        xact(1, 0, 32'h0000_3000, 32'h0, 2'b10, 0, 32'hDEAD_BEEF, 5, 4);
        checks++; if (r_lat !== 12) begin errors++; $display("FAIL bp_latency got %0d want 12", r_lat); end
        checks++; if (r_stall !== 12) begin errors++; $display("FAIL bp_stall_cycles got %0d want 12", r_stall); end
        checks++; if ({r_reqs, 31'd0, r_stable} !== {32'd6, 32'd1}) begin errors++; $display("FAIL bp_req got cycles %0d stable %0d want 6 1", r_reqs, r_stable); end
        checks++; if ({r_pulses, r_wb} !== {32'd1, 32'hDEAD_BEEF}) begin errors++; $display("FAIL bp_wb got pulses %0d data %h want 1 deadbeef", r_pulses, r_wb); end
    endtask

    task automatic test_misalign;
        xact(1, 0, 32'h0000_2001, 32'h0, 2'b10, 0, 32'h8001_7FFF, 0, 0);
`ifdef MIPS_LSU_MISALIGN_EXCP_EN
        checks++; if ({r_reqs, r_lat} !== {32'd0, 32'd1}) begin errors++; $display("FAIL lw_mis_bus got reqs %0d lat %0d want 0 1", r_reqs, r_lat); end
        checks++; if ({r_mis, r_wb} !== {1'b1, 32'h0}) begin errors++; $display("FAIL lw_mis_flag got %b %h want 1 0", r_mis, r_wb); end
`else
        checks++; if ({r_reqs, r_addr} !== {32'd1, 32'h0000_2000}) begin errors++; $display("FAIL lw_mis_bus got reqs %0d addr %h want 1 00002000", r_reqs, r_addr); end
        checks++; if ({r_mis, r_wb} !== {1'b0, 32'h8001_7FFF}) begin errors++; $display("FAIL lw_mis_data got %b %h want 0 80017fff", r_mis, r_wb); end
`endif
        xact(1, 0, 32'h0000_2003, 32'h0, 2'b01, 0, 32'h8001_7FFF, 0, 0);
`ifdef MIPS_LSU_MISALIGN_EXCP_EN
        checks++; if ({r_reqs, r_mis} !== {32'd0, 1'b1}) begin errors++; $display("FAIL lh_mis got reqs %0d flag %b want 0 1", r_reqs, r_mis); end
`else
        checks++; if ({r_mis, r_wb} !== {1'b0, 32'hFFFF_8001}) begin errors++; $display("FAIL lh_mis got %b %h want 0 ffff8001", r_mis, r_wb); end
`endif
    endtask

    task automatic test_reset_mid;
        lsu_req_read = 1; lsu_req_write = 0; lsu_req_addr = 32'h0000_4004; lsu_req_size = 2'b10;
        dmem_rsp_rdat = 32'h5555_AAAA; lsu_req_valid = 1; dmem_req_ready = 1;
        step();
        lsu_req_valid = 0;
        step();
        dmem_req_ready = 0;
        rst = 1;
        step();
        rst = 0; dmem_rsp_valid = 1;
        #1;
        checks++; if ({lsu_stall, dmem_req_valid, lsu_wb_valid, dmem_req_addr} !== 35'h0) begin errors++; $display("FAIL rst_mid_out got %b %b %b %h want 0 0 0 0", lsu_stall, dmem_req_valid, lsu_wb_valid, dmem_req_addr); end
        step();
        dmem_rsp_valid = 0;
        #1;
        checks++; if ({lsu_wb_valid, lsu_wb_data} !== 33'h0) begin errors++; $display("FAIL rst_late_rsp got %b %h want 0 0", lsu_wb_valid, lsu_wb_data); end
        xact(0, 1, 32'h0000_4008, 32'h0102_0304, 2'b10, 0, 32'h0, 0, 0);
        checks++; if ({r_lat, r_pulses, r_addr} !== {32'd3, 32'd1, 32'h0000_4008}) begin errors++; $display("FAIL rst_new_req got lat %0d pulses %0d addr %h want 3 1 00004008", r_lat, r_pulses, r_addr); end
    endtask

    initial begin
        test_reset();
        test_ignore();
        test_store();
        test_load();
        test_backpressure();
        test_misalign();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
